// File: rtl/stopwatch_pkg.sv
// Shared constants, converter state type and BCD-to-segment lookup for the
// stopwatch display path.
package stopwatch_pkg;

    localparam int unsigned NUM_DIGITS = 4;
    localparam int unsigned DP_DIGIT   = 2;
    localparam int unsigned BIN_W      = 6;
    localparam int unsigned DIGIT_W    = 4;
    localparam int unsigned SEG_W      = 7;

    // Active-low {g,f,e,d,c,b,a} patterns for a common-anode display.
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;
    localparam logic [SEG_W-1:0] SEG_0     = 7'b1000000;
    localparam logic [SEG_W-1:0] SEG_1     = 7'b1111001;
    localparam logic [SEG_W-1:0] SEG_2     = 7'b0100100;
    localparam logic [SEG_W-1:0] SEG_3     = 7'b0110000;
    localparam logic [SEG_W-1:0] SEG_4     = 7'b0011001;
    localparam logic [SEG_W-1:0] SEG_5     = 7'b0010010;
    localparam logic [SEG_W-1:0] SEG_6     = 7'b0000010;
    localparam logic [SEG_W-1:0] SEG_7     = 7'b1111000;
    localparam logic [SEG_W-1:0] SEG_8     = 7'b0000000;
    localparam logic [SEG_W-1:0] SEG_9     = 7'b0010000;

    typedef enum logic [1:0] {
        CONV_IDLE,
        CONV_SHIFT,
        CONV_DONE
    } conv_state_t;

    // Nibbles above 9 should never reach here; show them blank rather than garbage.
    function automatic logic [SEG_W-1:0] bcd_to_seg(input logic [DIGIT_W-1:0] digit);
        logic [SEG_W-1:0] seg;
        case (digit)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/bin2bcd6.sv
// Sequential shift-add-3 converter: 6-bit binary to two BCD digits.
// Ports: clock, reset (sync, active-high), start (load bin when idle),
//        bin[5:0], busy (conversion in flight), done (result valid this cycle),
//        tens[3:0], ones[3:0].
module bin2bcd6
    import stopwatch_pkg::*;
(
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic [BIN_W-1:0]     bin,
    output logic                 busy,
    output logic                 done,
    output logic [DIGIT_W-1:0]   tens,
    output logic [DIGIT_W-1:0]   ones
);

    localparam int unsigned ITER_W = 3;

    conv_state_t           state_q;
    conv_state_t           state_d;
    logic [BIN_W-1:0]      bin_q;
    logic [2*DIGIT_W-1:0]  bcd_q;
    logic [2*DIGIT_W-1:0]  bcd_adj;
    logic [ITER_W-1:0]     iter_q;

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= CONV_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: a start while not idle is ignored.
    always_comb begin
        state_d = state_q;
        case (state_q)
            CONV_IDLE:  if (start) state_d = CONV_SHIFT;
            CONV_SHIFT: if (iter_q == ITER_W'(BIN_W - 1)) state_d = CONV_DONE;
            CONV_DONE:  state_d = CONV_IDLE;
            default:    state_d = CONV_IDLE;
        endcase
    end

    // Add-3 correction applied to each nibble before the shift.
    always_comb begin
        bcd_adj = bcd_q;
        if (bcd_q[3:0] >= 4'd5) bcd_adj[3:0] = bcd_q[3:0] + 4'd3;
        if (bcd_q[7:4] >= 4'd5) bcd_adj[7:4] = bcd_q[7:4] + 4'd3;
    end

    // Datapath: capture on start, then shift one binary MSB in per iteration.
    always_ff @(posedge clock) begin
        if (reset) begin
            bin_q  <= '0;
            bcd_q  <= '0;
            iter_q <= '0;
        end else begin
            case (state_q)
                CONV_IDLE: begin
                    if (start) begin
                        bin_q  <= bin;
                        bcd_q  <= '0;
                        iter_q <= '0;
                    end
                end
                CONV_SHIFT: begin
                    bcd_q  <= (2*DIGIT_W)'({bcd_adj, bin_q[BIN_W-1]});
                    bin_q  <= {bin_q[BIN_W-2:0], 1'b0};
                    iter_q <= iter_q + ITER_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign busy = (state_q != CONV_IDLE);
    assign done = (state_q == CONV_DONE);
    assign tens = bcd_q[2*DIGIT_W-1:DIGIT_W];
    assign ones = bcd_q[DIGIT_W-1:0];

endmodule

// File: rtl/stopwatch_display.sv
// Four-digit multiplexed seven-segment driver showing MM.SS on a
// common-anode display.
// Ports: clock, reset (sync, active-high), minutes[5:0], seconds[5:0] (binary),
//        anode[3:0] (active-low, bit 0 rightmost), segments[6:0] ({g..a},
//        active-low), dp (active-low), update (pulse on digit commit).
module stopwatch_display
    import stopwatch_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 50000
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [BIN_W-1:0]      minutes,
    input  logic [BIN_W-1:0]      seconds,
    output logic [NUM_DIGITS-1:0] anode,
    output logic [SEG_W-1:0]      segments,
    output logic                  dp,
    output logic                  update
);

    localparam int unsigned PRE_W = $clog2(REFRESH_DIV);
    localparam int unsigned IDX_W = $clog2(NUM_DIGITS);

    logic [PRE_W-1:0]    presc_q;
    logic [IDX_W-1:0]    idx_q;
    logic                first_q;
    logic [DIGIT_W-1:0]  digit_q [NUM_DIGITS];

    logic                terminal;
    logic                snapshot;
    logic                start;
    logic                commit;
    logic                min_busy, sec_busy;
    logic                min_done, sec_done;
    logic [DIGIT_W-1:0]  min_tens, min_ones, sec_tens, sec_ones;

    // Snapshot on every frame wrap and once right after reset; dropped if busy.
    assign terminal = (presc_q == PRE_W'(REFRESH_DIV - 1));
    assign snapshot = first_q | (terminal & (idx_q == IDX_W'(NUM_DIGITS - 1)));
    assign start    = snapshot & ~min_busy & ~sec_busy;
    assign commit   = min_done & sec_done;

    bin2bcd6 u_min_conv (
        .clock (clock),
        .reset (reset),
        .start (start),
        .bin   (minutes),
        .busy  (min_busy),
        .done  (min_done),
        .tens  (min_tens),
        .ones  (min_ones)
    );

    bin2bcd6 u_sec_conv (
        .clock (clock),
        .reset (reset),
        .start (start),
        .bin   (seconds),
        .busy  (sec_busy),
        .done  (sec_done),
        .tens  (sec_tens),
        .ones  (sec_ones)
    );

    // Scan timing, atomic digit commit and registered pin drivers.
    always_ff @(posedge clock) begin
        if (reset) begin
            presc_q    <= '0;
            idx_q      <= '0;
            first_q    <= 1'b1;
            digit_q[0] <= '0;
            digit_q[1] <= '0;
            digit_q[2] <= '0;
            digit_q[3] <= '0;
            anode      <= '1;
            segments   <= SEG_BLANK;
            dp         <= 1'b1;
            update     <= 1'b0;
        end else begin
            presc_q <= terminal ? '0 : presc_q + PRE_W'(1);
            if (terminal) idx_q <= idx_q + IDX_W'(1);
            first_q <= 1'b0;
            if (commit) begin
                digit_q[0] <= sec_ones;
                digit_q[1] <= sec_tens;
                digit_q[2] <= min_ones;
                digit_q[3] <= min_tens;
            end
            update   <= commit;
            anode    <= ~(NUM_DIGITS'(1) << idx_q);
            segments <= bcd_to_seg(digit_q[idx_q]);
            dp       <= (idx_q != IDX_W'(DP_DIGIT));
        end
    end

endmodule
